// File: rtl/pkt_loss_monitor_vrf_pkg.sv
// Shared types and defaults for the receive-side PSN loss monitor.
// Also supplies default beat widths when the build does not define them.
`ifndef PKT_HEAD_WIDTH
`define PKT_HEAD_WIDTH 64
`endif
`ifndef PKT_DATA_WIDTH
`define PKT_DATA_WIDTH 64
`endif

package pkt_loss_monitor_vrf_pkg;

  localparam int PSN_LSB_DEF   = 0;
  localparam int PSN_WIDTH_DEF = 24;
  localparam int CNT_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_IN_PKT = 2'd2
  } mon_state_e;

  // Result of comparing a received PSN against the expected PSN.
  typedef enum logic [1:0] {
    PSN_INORDER = 2'd0,
    PSN_GAP     = 2'd1,
    PSN_DUP     = 2'd2
  } psn_class_e;

endpackage

// File: rtl/pkt_loss_monitor_vrf_psn_checker.sv
// PSN classification (in order / gap / duplicate) and the saturating
// statistics counters plus the expected-PSN register.
module pkt_loss_psn_checker
  import pkt_loss_monitor_vrf_pkg::*;
#(
  parameter int PSN_WIDTH = PSN_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 check_i,
  input  logic                 sync_i,
  input  logic [PSN_WIDTH-1:0] psn_i,
  output logic                 dup_o,
  output logic [PSN_WIDTH-1:0] expected_psn_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o,
  output logic [CNT_WIDTH-1:0] loss_cnt_o,
  output logic [CNT_WIDTH-1:0] dup_cnt_o,
  output logic                 loss_pulse_o
);

  localparam int SUM_W = ((CNT_WIDTH > PSN_WIDTH) ? CNT_WIDTH : PSN_WIDTH) + 1;
  localparam logic [PSN_WIDTH-1:0] PSN_ONE = PSN_WIDTH'(1);

  logic [PSN_WIDTH-1:0] exp_q, exp_d, diff;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d, loss_q, loss_d, dup_q, dup_d;
  logic                 pulse_q, pulse_d;
  psn_class_e           cls;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic [PSN_WIDTH-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(inc);
    if (sum > SUM_W'({CNT_WIDTH{1'b1}})) return '1;
    return sum[CNT_WIDTH-1:0];
  endfunction

  // Forward distances below half the PSN space are gaps; the rest are
  // treated as retransmissions of already-seen packets.
  function automatic psn_class_e classify(input logic [PSN_WIDTH-1:0] d);
    if (d == '0) return PSN_INORDER;
    if (!d[PSN_WIDTH-1]) return PSN_GAP;
    return PSN_DUP;
  endfunction

  always_comb begin
    diff    = psn_i - exp_q;
    cls     = classify(diff);
    dup_o   = check_i && !sync_i && (cls == PSN_DUP);
    exp_d   = clear_i ? '0 : exp_q;
    pkt_d   = clear_i ? '0 : pkt_q;
    loss_d  = clear_i ? '0 : loss_q;
    dup_d   = clear_i ? '0 : dup_q;
    pulse_d = 1'b0;
    if (check_i) begin
      if (sync_i) begin
        pkt_d = sat_add(pkt_d, PSN_ONE);
        exp_d = psn_i + PSN_ONE;
      end else begin
        case (cls)
          PSN_INORDER: begin
            pkt_d = sat_add(pkt_d, PSN_ONE);
            exp_d = psn_i + PSN_ONE;
          end
          PSN_GAP: begin
            loss_d  = sat_add(loss_d, diff);
            pkt_d   = sat_add(pkt_d, PSN_ONE);
            exp_d   = psn_i + PSN_ONE;
            pulse_d = 1'b1;
          end
          default: dup_d = sat_add(dup_d, PSN_ONE);
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q   <= '0;
      pkt_q   <= '0;
      loss_q  <= '0;
      dup_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      exp_q   <= exp_d;
      pkt_q   <= pkt_d;
      loss_q  <= loss_d;
      dup_q   <= dup_d;
      pulse_q <= pulse_d;
    end
  end

  assign expected_psn_o = exp_q;
  assign pkt_cnt_o      = pkt_q;
  assign loss_cnt_o     = loss_q;
  assign dup_cnt_o      = dup_q;
  assign loss_pulse_o   = pulse_q;

endmodule

// File: rtl/pkt_loss_monitor_vrf.sv
// Far-end receive monitor: one-stage pass-through, framing FSM and PSN loss stats.
// Optional LOSS_MON_DROP_DUP_EN: packets classified as duplicates are swallowed.
`ifndef PKT_HEAD_WIDTH
`define PKT_HEAD_WIDTH 64
`endif
`ifndef PKT_DATA_WIDTH
`define PKT_DATA_WIDTH 64
`endif

module pkt_loss_monitor_vrf
  import pkt_loss_monitor_vrf_pkg::*;
#(
  parameter int PSN_LSB   = PSN_LSB_DEF,
  parameter int PSN_WIDTH = PSN_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_recv_valid,
  input  logic [`PKT_HEAD_WIDTH-1:0] iv_recv_head,
  input  logic [`PKT_DATA_WIDTH-1:0] iv_recv_data,
  input  logic                       i_recv_start,
  input  logic                       i_recv_last,
  output logic                       o_recv_ready,
  output logic                       o_send_valid,
  output logic [`PKT_HEAD_WIDTH-1:0] ov_send_head,
  output logic [`PKT_DATA_WIDTH-1:0] ov_send_data,
  output logic                       o_send_start,
  output logic                       o_send_last,
  input  logic                       i_send_ready,
  input  logic                       i_clear,
  output logic [PSN_WIDTH-1:0]       ov_expected_psn,
  output logic [CNT_WIDTH-1:0]       ov_pkt_cnt,
  output logic [CNT_WIDTH-1:0]       ov_loss_cnt,
  output logic [CNT_WIDTH-1:0]       ov_dup_cnt,
  output logic                       o_loss_pulse,
  output logic                       o_proto_err
);

  localparam int HW = `PKT_HEAD_WIDTH;
  localparam int DW = `PKT_DATA_WIDTH;

  mon_state_e    state_q, state_d;
  logic          proto_err_q, proto_err_d;
  logic          send_valid_q, send_start_q, send_last_q;
  logic [HW-1:0] send_head_q;
  logic [DW-1:0] send_data_q;
  logic          accept, check, sync, is_dup, drop_beat;

  assign accept = i_recv_valid && o_recv_ready;
  assign check  = accept && i_recv_start;
  assign sync   = (state_q == ST_SYNC) || i_clear;

`ifdef LOSS_MON_DROP_DUP_EN
  logic drop_q, drop_d;

  // Continuation beats of a swallowed packet never touch the output register,
  // so they can be taken even while the downstream is stalled.
  assign o_recv_ready = !send_valid_q || i_send_ready ||
                        (drop_q && !i_recv_start && !i_clear);

  always_comb begin
    drop_d    = i_clear ? 1'b0 : drop_q;
    drop_beat = 1'b0;
    if (accept) begin
      if (i_recv_start) begin
        drop_beat = is_dup;
        drop_d    = is_dup && !i_recv_last;
      end else if (!i_clear) begin
        drop_beat = drop_q;
        if (i_recv_last) drop_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= drop_d;
  end
`else
  logic unused_dup;
  assign unused_dup   = is_dup;
  assign drop_beat    = 1'b0;
  assign o_recv_ready = !send_valid_q || i_send_ready;
`endif

  // Pass-through register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_valid_q <= 1'b0;
      send_start_q <= 1'b0;
      send_last_q  <= 1'b0;
      send_head_q  <= '0;
      send_data_q  <= '0;
    end else if (accept && !drop_beat) begin
      send_valid_q <= 1'b1;
      send_start_q <= i_recv_start;
      send_last_q  <= i_recv_last;
      send_head_q  <= iv_recv_head;
      send_data_q  <= iv_recv_data;
    end else if (i_send_ready) begin
      send_valid_q <= 1'b0;
    end
  end

  // Framing FSM: a clear forces SYNC but a coincident start beat still opens a packet.
  always_comb begin
    state_d     = i_clear ? ST_SYNC : state_q;
    proto_err_d = i_clear ? 1'b0 : proto_err_q;
    if (accept) begin
      if (i_recv_start) begin
        state_d = i_recv_last ? ST_IDLE : ST_IN_PKT;
        if ((state_q == ST_IN_PKT) && !i_clear) proto_err_d = 1'b1;
      end else if (state_d == ST_IN_PKT) begin
        if (i_recv_last) state_d = ST_IDLE;
      end else if (!i_clear) begin
        proto_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      proto_err_q <= proto_err_d;
    end
  end

  pkt_loss_psn_checker #(
    .PSN_WIDTH (PSN_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_checker (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (i_clear),
    .check_i        (check),
    .sync_i         (sync),
    .psn_i          (iv_recv_head[PSN_LSB +: PSN_WIDTH]),
    .dup_o          (is_dup),
    .expected_psn_o (ov_expected_psn),
    .pkt_cnt_o      (ov_pkt_cnt),
    .loss_cnt_o     (ov_loss_cnt),
    .dup_cnt_o      (ov_dup_cnt),
    .loss_pulse_o   (o_loss_pulse)
  );

  assign o_send_valid = send_valid_q;
  assign o_send_start = send_start_q;
  assign o_send_last  = send_last_q;
  assign ov_send_head = send_head_q;
  assign ov_send_data = send_data_q;
  assign o_proto_err  = proto_err_q;

endmodule

// File: tb/tb_pkt_loss_monitor_vrf.sv
// Randomised self-checking bench for pkt_loss_monitor_vrf with a beat-level reference model.
`timescale 1ns/1ps
`ifndef PKT_HEAD_WIDTH
`define PKT_HEAD_WIDTH 64
`endif
`ifndef PKT_DATA_WIDTH
`define PKT_DATA_WIDTH 64
`endif

module tb_pkt_loss_monitor_vrf;
  localparam int HW = `PKT_HEAD_WIDTH;
  localparam int DW = `PKT_DATA_WIDTH;
  localparam int PW = 24;
  localparam int CW = 32;
  localparam int OW = HW + DW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_recv_valid = 1'b0, i_recv_start = 1'b0, i_recv_last = 1'b0;
  logic [HW-1:0] iv_recv_head = '0;
  logic [DW-1:0] iv_recv_data = '0;
  logic          o_recv_ready, o_send_valid, o_send_start, o_send_last;
  logic [HW-1:0] ov_send_head;
  logic [DW-1:0] ov_send_data;
  logic          i_send_ready = 1'b1, i_clear = 1'b0;
  logic [PW-1:0] ov_expected_psn;
  logic [CW-1:0] ov_pkt_cnt, ov_loss_cnt, ov_dup_cnt;
  logic          o_loss_pulse, o_proto_err;

  pkt_loss_monitor_vrf #(.PSN_LSB(0), .PSN_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .i_recv_valid(i_recv_valid), .iv_recv_head(iv_recv_head), .iv_recv_data(iv_recv_data),
    .i_recv_start(i_recv_start), .i_recv_last(i_recv_last), .o_recv_ready(o_recv_ready),
    .o_send_valid(o_send_valid), .ov_send_head(ov_send_head), .ov_send_data(ov_send_data),
    .o_send_start(o_send_start), .o_send_last(o_send_last), .i_send_ready(i_send_ready),
    .i_clear(i_clear), .ov_expected_psn(ov_expected_psn), .ov_pkt_cnt(ov_pkt_cnt),
    .ov_loss_cnt(ov_loss_cnt), .ov_dup_cnt(ov_dup_cnt), .o_loss_pulse(o_loss_pulse),
    .o_proto_err(o_proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [HW-1:0] head;
    logic [DW-1:0] data;
    bit            st;
    bit            ls;
    bit            gap;
  } beat_t;

  beat_t         q[$];
  beat_t         mon_e;
  int            n_cmp = 0, n_fail = 0, pulse_cnt = 0;
  bit            bp_en = 0, stall = 0, hold_v = 0;
  logic [OW-1:0] held;

  logic [CW-1:0] m_pkt, m_loss, m_dup;
  logic [PW-1:0] m_exp;
  bit            m_err, m_sync, m_inpkt, m_drop;

  function automatic void model_clear();
    m_pkt = '0; m_loss = '0; m_dup = '0; m_exp = '0;
    m_err = 0; m_sync = 1; m_inpkt = 0; m_drop = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    q.delete();
  endfunction

  function automatic void model_beat(bit st, bit ls, logic [PW-1:0] psn, bit clr,
                                     logic [HW-1:0] h, logic [DW-1:0] d);
    bit            fwd = 1, gap = 0;
    logic [PW-1:0] df;
    if (clr) model_clear();
    if (st) begin
      if (m_inpkt) m_err = 1;
      m_drop = 0;
      if (m_sync) begin
        if (m_pkt != '1) m_pkt++;
        m_exp  = psn + PW'(1);
        m_sync = 0;
      end else begin
        df = psn - m_exp;
        if (df == 0) begin
          if (m_pkt != '1) m_pkt++;
          m_exp = psn + PW'(1);
        end else if (df < 24'h800000) begin
          m_loss = (64'(m_loss) + 64'(df) > 64'hFFFF_FFFF) ? '1 : m_loss + CW'(df);
          if (m_pkt != '1) m_pkt++;
          m_exp = psn + PW'(1);
          gap   = 1;
        end else begin
          if (m_dup != '1) m_dup++;
`ifdef LOSS_MON_DROP_DUP_EN
          fwd    = 0;
          m_drop = !ls;
`endif
        end
      end
      m_inpkt = !ls;
    end else if (!m_inpkt) begin
      if (!clr) m_err = 1;
    end else begin
      if (m_drop) fwd = 0;
      if (ls) begin m_inpkt = 0; m_drop = 0; end
    end
    if (fwd) q.push_back('{h, d, st, ls, gap});
  endfunction

  // Downstream ready generator.
  initial forever begin
    @(posedge clk); #1;
    if (stall) i_send_ready = 1'b0;
    else if (bp_en) i_send_ready = ($urandom_range(0, 3) != 0);
    else i_send_ready = 1'b1;
  end

  // Output stream scoreboard and hold-stability monitor.
  always @(negedge clk) begin
    if (rst) hold_v = 0;
    else begin
      if (o_loss_pulse) pulse_cnt++;
      if (hold_v) begin
        n_cmp++;
        if ({o_send_valid, o_send_start, o_send_last, ov_send_head, ov_send_data} !== held) begin
          n_fail++;
          $display("FAIL hold_stable got %h want %h",
                   {o_send_valid, o_send_start, o_send_last, ov_send_head, ov_send_data}, held);
        end
      end
      if (o_send_valid && i_send_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_beat got head=%h data=%h want no beat", ov_send_head, ov_send_data);
        end else begin
          mon_e = q.pop_front();
          if ({ov_send_head, ov_send_data, o_send_start, o_send_last} !==
              {mon_e.head, mon_e.data, mon_e.st, mon_e.ls}) begin
            n_fail++;
            $display("FAIL out_beat got %h/%h s%b l%b want %h/%h s%b l%b", ov_send_head, ov_send_data,
                     o_send_start, o_send_last, mon_e.head, mon_e.data, mon_e.st, mon_e.ls);
          end
          if (!bp_en && !stall) begin
            n_cmp++;
            if (o_loss_pulse !== mon_e.gap) begin
              n_fail++;
              $display("FAIL loss_pulse_align got %b want %b", o_loss_pulse, mon_e.gap);
            end
          end
        end
      end
      hold_v = o_send_valid && !i_send_ready;
      held   = {o_send_valid, o_send_start, o_send_last, ov_send_head, ov_send_data};
    end
  end

  task automatic to_edge();
    @(posedge clk); #1;
  endtask

  task automatic drive_beat(input bit st, input bit ls, input logic [PW-1:0] psn, input bit clr);
    logic [HW-1:0] h;
    logic [DW-1:0] d;
    bit            acc = 0;
    h = HW'({$urandom, $urandom});
    h[PW-1:0] = psn;
    d = DW'({$urandom, $urandom});
    i_recv_valid = 1; i_recv_start = st; i_recv_last = ls;
    iv_recv_head = h; iv_recv_data = d; i_clear = clr;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk); acc = o_recv_ready;
      to_edge();
    end
    i_clear = 0;
    if (acc) model_beat(st, ls, psn, clr, h, d);
    else begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout got ready=0 for 200 cycles want accepted");
    end
  endtask

  task automatic go_idle();
    i_recv_valid = 0; i_recv_start = 0; i_recv_last = 0;
  endtask

  task automatic send_pkt(input logic [PW-1:0] psn, input int nb);
    for (int b = 0; b < nb; b++) drive_beat(b == 0, b == nb - 1, psn, 0);
  endtask

  task automatic do_clear();
    i_clear = 1; to_edge(); i_clear = 0;
    model_clear();
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 1000 && (q.size() != 0 || o_send_valid); k++) to_edge();
    @(negedge clk);
  endtask

  task automatic check_model(input string name);
    n_cmp++;
    if ({ov_pkt_cnt, ov_loss_cnt, ov_dup_cnt, ov_expected_psn, o_proto_err} !==
        {m_pkt, m_loss, m_dup, m_exp, m_err} || q.size() != 0) begin
      n_fail++;
      $display("FAIL %s got pkt=%0d loss=%0d dup=%0d exp=%h err=%b pend=%0d want pkt=%0d loss=%0d dup=%0d exp=%h err=%b pend=0",
               name, ov_pkt_cnt, ov_loss_cnt, ov_dup_cnt, ov_expected_psn, o_proto_err, q.size(),
               m_pkt, m_loss, m_dup, m_exp, m_err);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({o_send_valid, o_send_start, o_send_last, ov_send_head, ov_send_data} !== '0 ||
        o_recv_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_datapath got v%b s%b l%b rdy%b want v0 s0 l0 rdy1",
               o_send_valid, o_send_start, o_send_last, o_recv_ready);
    end
    n_cmp++;
    if ({ov_pkt_cnt, ov_loss_cnt, ov_dup_cnt, ov_expected_psn, o_loss_pulse, o_proto_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_stats got pkt=%0d loss=%0d dup=%0d exp=%h pulse=%b err=%b want all 0",
               ov_pkt_cnt, ov_loss_cnt, ov_dup_cnt, ov_expected_psn, o_loss_pulse, o_proto_err);
    end
    model_reset();
    to_edge();
    rst = 0;
  endtask

  task automatic test_inorder();
    for (int p = 0; p < 10; p++) begin
      drive_beat(1, 1, PW'(p), 0);
      if (p == 0) begin
        n_cmp++;
        if (o_send_valid !== 1'b1 || o_send_start !== 1'b1 || ov_send_head[PW-1:0] !== '0) begin
          n_fail++;
          $display("FAIL latency got v%b s%b psn=%h want v1 s1 psn=0",
                   o_send_valid, o_send_start, ov_send_head[PW-1:0]);
        end
      end
    end
    go_idle(); wait_drain();
    check_model("inorder_model");
    n_cmp++;
    if (ov_pkt_cnt !== 10 || ov_loss_cnt !== 0 || ov_dup_cnt !== 0 || ov_expected_psn !== 10) begin
      n_fail++;
      $display("FAIL inorder_const got pkt=%0d loss=%0d dup=%0d exp=%0d want 10/0/0/10",
               ov_pkt_cnt, ov_loss_cnt, ov_dup_cnt, ov_expected_psn);
    end
    to_edge();
  endtask

  task automatic test_gap();
    int p0;
    do_clear();
    p0 = pulse_cnt;
    send_pkt(0, 1); send_pkt(1, 1); send_pkt(2, 1); send_pkt(5, 1);
    go_idle(); wait_drain();
    check_model("gap_model");
    n_cmp++;
    if (ov_loss_cnt !== 2 || ov_expected_psn !== 6 || pulse_cnt - p0 != 1) begin
      n_fail++;
      $display("FAIL gap_const got loss=%0d exp=%0d pulses=%0d want 2/6/1",
               ov_loss_cnt, ov_expected_psn, pulse_cnt - p0);
    end
    to_edge();
  endtask

  task automatic test_dup();
    do_clear();
    send_pkt(0, 1); send_pkt(1, 1); send_pkt(2, 1); send_pkt(1, 4);
    go_idle(); wait_drain();
    check_model("dup_model");
    n_cmp++;
    if (ov_dup_cnt !== 1 || ov_expected_psn !== 3 || ov_pkt_cnt !== 3) begin
      n_fail++;
      $display("FAIL dup_const got dup=%0d exp=%0d pkt=%0d want 1/3/3",
               ov_dup_cnt, ov_expected_psn, ov_pkt_cnt);
    end
    to_edge();
  endtask

  task automatic test_wrap();
    do_clear();
    send_pkt(24'hFFFFFD, 1); send_pkt(24'hFFFFFE, 2); send_pkt(24'hFFFFFF, 1); send_pkt(24'h000001, 2);
    go_idle(); wait_drain();
    check_model("wrap_model");
    n_cmp++;
    if (ov_loss_cnt !== 1 || ov_expected_psn !== 2) begin
      n_fail++;
      $display("FAIL wrap_const got loss=%0d exp=%h want 1/000002", ov_loss_cnt, ov_expected_psn);
    end
    to_edge();
  endtask

  task automatic test_back_to_back();
    do_clear();
    bp_en = 1;
    for (int p = 0; p < 25; p++) send_pkt(PW'(p + 100), 3);
    go_idle(); wait_drain();
    bp_en = 0;
    check_model("backpressure_model");
    n_cmp++;
    if (ov_pkt_cnt !== 25 || ov_loss_cnt !== 0) begin
      n_fail++;
      $display("FAIL backpressure_const got pkt=%0d loss=%0d want 25/0", ov_pkt_cnt, ov_loss_cnt);
    end
    to_edge();
  endtask

  task automatic test_random();
    int            r;
    logic [PW-1:0] psn;
    do_clear();
    bp_en = 1;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (n == 0 || r < 6) psn = m_exp;
      else if (r < 8) psn = m_exp + PW'($urandom_range(1, 4));
      else psn = m_exp - PW'($urandom_range(1, 3));
      send_pkt(psn, $urandom_range(1, 4));
    end
    go_idle(); wait_drain();
    bp_en = 0;
    check_model("random_model");
    to_edge();
  endtask

  task automatic test_proto();
    do_clear();
    drive_beat(1, 0, 24'h20, 0);
    drive_beat(0, 0, 24'h0, 0);
    drive_beat(1, 0, 24'h21, 0);
    drive_beat(0, 1, 24'h0, 0);
    go_idle(); wait_drain();
    check_model("proto_model");
    n_cmp++;
    if (o_proto_err !== 1'b1 || ov_pkt_cnt !== 2 || ov_expected_psn !== 24'h22) begin
      n_fail++;
      $display("FAIL proto_const got err=%b pkt=%0d exp=%h want 1/2/000022",
               o_proto_err, ov_pkt_cnt, ov_expected_psn);
    end
    to_edge();
    do_clear();
    @(negedge clk);
    n_cmp++;
    if ({ov_pkt_cnt, ov_loss_cnt, ov_dup_cnt, o_proto_err} !== '0) begin
      n_fail++;
      $display("FAIL clear_const got pkt=%0d loss=%0d dup=%0d err=%b want all 0",
               ov_pkt_cnt, ov_loss_cnt, ov_dup_cnt, o_proto_err);
    end
    to_edge();
    send_pkt(24'h123, 2);
    go_idle(); wait_drain();
    n_cmp++;
    if (ov_expected_psn !== 24'h124 || ov_pkt_cnt !== 1) begin
      n_fail++;
      $display("FAIL resync_const got exp=%h pkt=%0d want 000124/1", ov_expected_psn, ov_pkt_cnt);
    end
    to_edge();
    drive_beat(0, 1, 24'h0, 0);
    go_idle(); wait_drain();
    check_model("stray_beat_model");
    to_edge();
  endtask

  task automatic test_clear_start();
    drive_beat(1, 1, 24'h50, 1);
    go_idle(); wait_drain();
    check_model("clear_start_model");
    n_cmp++;
    if (ov_pkt_cnt !== 1 || ov_expected_psn !== 24'h51 || o_proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_start_const got pkt=%0d exp=%h err=%b want 1/000051/0",
               ov_pkt_cnt, ov_expected_psn, o_proto_err);
    end
    to_edge();
  endtask

  task automatic test_reset_midpacket();
    stall = 1;
    to_edge();
    drive_beat(1, 0, 24'h7, 0);
    go_idle();
    #2 rst = 1;
    #1;
    n_cmp++;
    if (o_send_valid !== 1'b0 || o_recv_ready !== 1'b1 || ov_pkt_cnt !== 0 || ov_expected_psn !== 0) begin
      n_fail++;
      $display("FAIL async_reset got v%b rdy%b pkt=%0d exp=%h want v0 rdy1 pkt=0 exp=0",
               o_send_valid, o_recv_ready, ov_pkt_cnt, ov_expected_psn);
    end
    model_reset();
    stall = 0;
    to_edge(); to_edge();
    rst = 0;
    send_pkt(24'h7, 2);
    go_idle(); wait_drain();
    check_model("post_reset_model");
    to_edge();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_inorder();
    test_gap();
    test_dup();
    test_wrap();
    test_back_to_back();
    test_random();
    test_proto();
    test_clear_start();
    test_reset_midpacket();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
